dmem_responder: RTL and testbench

- Target side of the MEM-stage data-memory interface.
- Accepts read/write requests from the pipeline's memory stage and services them against an internal 16-bit-wide word array with programmable wait states.
- Returns read data with a one-cycle ack pulse.
- Supports 32-bit "wide" transfers as two 16-bit beats, used for PC push/pop to the stack on call/interrupt/return.
- Drives busy so the pipeline stalls MEM while a transfer is in flight.

---
 rtl/dmem_responder_if.sv | 38 +++
 rtl/dmem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the pipeline MEM stage (master) and the
// data-memory responder (slave).
//   req_rd / req_wr / req_wide  : operation select (master -> slave)
//   req_addr [ADDR_W]           : word address (master -> slave)
//   req_wdata [2*DATA_W]        : write data; narrow writes use the low word
//   busy                        : transfer in flight (slave -> master)
//   ack                         : one-cycle completion pulse (slave -> master)
//   rdata [2*DATA_W]            : read data, valid while ack is high
//   fault                       : address out of range, valid with ack
//   req_conflict                : pulse when read and write arrive together
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) ();
    logic                  req_rd;
    logic                  req_wr;
    logic                  req_wide;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  busy;
    logic                  ack;
    logic [2*DATA_W-1:0]   rdata;
    logic                  fault;
    logic                  req_conflict;

    modport master (
        output req_rd, req_wr, req_wide, req_addr, req_wdata,
        input  busy, ack, rdata, fault, req_conflict
    );

    modport slave (
        input  req_rd, req_wr, req_wide, req_addr, req_wdata,
        output busy, ack, rdata, fault, req_conflict
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Target side of the MEM-stage data-memory port. Requests are latched on
// acceptance, optionally delayed by WAIT_CYCLES idle cycles, then serviced as
// one (narrow) or two (wide) 16-bit beats against an internal word array.
// Completion is signalled by a one-cycle ack with busy low.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (array contents are kept)
//   bus  : dmem_responder_if.slave (request inputs, busy/ack/rdata/fault/
//          req_conflict outputs, all outputs registered)
//
// Optional build macro: DMEM_BOUNDS_EN
//   When defined, transfers touching a word above LIMIT (or a wide transfer
//   that would wrap) complete immediately with fault=1 and no array access.
//   When undefined, fault is always 0 and wide accesses wrap modulo 2^ADDR_W.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int LIMIT       = 4095
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_BEAT0 = 3'd2;
    localparam logic [2:0] ST_BEAT1 = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Last value of the wait counter before moving on to the first beat.
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [2:0] ST_FIRST  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BEAT0;

    logic [2:0]           state_q,    state_d;
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]    addr_q,     addr_d;
    logic [2*DATA_W-1:0]  wdata_q,    wdata_d;
    logic                 wide_q,     wide_d;
    logic                 wr_q,       wr_d;
    logic                 busy_q,     busy_d;
    logic                 ack_q,      ack_d;
    logic [2*DATA_W-1:0]  rdata_q,    rdata_d;
    logic                 fault_q,    fault_d;
    logic                 conflict_q, conflict_d;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic                 mem_we_s;
    logic [ADDR_W-1:0]    mem_waddr_s;
    logic [DATA_W-1:0]    mem_wdata_s;
    logic [ADDR_W-1:0]    addr_p1_s;
    logic [DATA_W-1:0]    rd0_s;
    logic [DATA_W-1:0]    rd1_s;
    logic                 req_any_s;
    logic                 bad_s;

    // Second beat address wraps naturally at ADDR_W bits.
    assign addr_p1_s = addr_q + ADDR_W'(1);
    assign rd0_s     = mem[addr_q];
    assign rd1_s     = mem[addr_p1_s];
    assign req_any_s = bus.req_rd | bus.req_wr;

`ifdef DMEM_BOUNDS_EN
    localparam logic [ADDR_W:0] LIMIT_W = (ADDR_W+1)'(LIMIT);
    logic [ADDR_W:0] req_addr_ext_s;
    assign req_addr_ext_s = {1'b0, bus.req_addr};
    // Wide at the top word would wrap; treat it as out of range as well.
    assign bad_s = (req_addr_ext_s > LIMIT_W)
                 | (bus.req_wide & ((req_addr_ext_s + (ADDR_W+1)'(1)) > LIMIT_W))
                 | (bus.req_wide & (&bus.req_addr));
`else
    assign bad_s = 1'b0;
`endif

    // Transfer FSM next-state, beat datapath and output next values.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wide_d      = wide_q;
        wr_d        = wr_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        conflict_d  = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_q;
        mem_wdata_s = wdata_q[DATA_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    wide_d     = bus.req_wide;
                    wr_d       = bus.req_wr;      // write wins on conflict
                    conflict_d = bus.req_rd & bus.req_wr;
                    wait_cnt_d = 4'd0;
                    if (bad_s) begin
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                        fault_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_FIRST;
                        busy_d  = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_BEAT0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_BEAT0: begin
                if (wr_q) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = addr_q;
                    mem_wdata_s = wdata_q[DATA_W-1:0];
                end else begin
                    rdata_d[DATA_W-1:0] = rd0_s;
                    // Narrow reads zero-extend; wide reads fill the top at beat 1.
                    rdata_d[2*DATA_W-1:DATA_W] = wide_q ? rdata_q[2*DATA_W-1:DATA_W]
                                                        : {DATA_W{1'b0}};
                end
                if (wide_q) begin
                    state_d = ST_BEAT1;
                end else begin
                    state_d = ST_DONE;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_BEAT1: begin
                if (wr_q) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = addr_p1_s;
                    mem_wdata_s = wdata_q[2*DATA_W-1:DATA_W];
                end else begin
                    rdata_d[2*DATA_W-1:DATA_W] = rd1_s;
                end
                state_d = ST_DONE;
                ack_d   = 1'b1;
                busy_d  = 1'b0;
            end
            ST_DONE: begin
                // Requests seen on the edge leaving DONE are dropped.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {(2*DATA_W){1'b0}};
            wide_q     <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= {(2*DATA_W){1'b0}};
            fault_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wide_q     <= wide_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            conflict_q <= conflict_d;
        end
    end

    // Word array; not cleared by reset, and a reset edge blocks a pending beat.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.ack          = ack_q;
    assign bus.rdata        = rdata_q;
    assign bus.fault        = fault_q;
    assign bus.req_conflict = conflict_q;
endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed transfers with hand-computed expectations. Stimulus pushes the
// expected latency / fault / rdata of each accepted request into queues; a
// negedge monitor pops and compares whenever ack is seen.
// Latency is counted as rising edges from the accept edge (exclusive) to the
// edge that samples ack high.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int WC = 1;
`ifdef DMEM_BOUNDS_EN
    localparam int LIM = 'h7FF;
`else
    localparam int LIM = 4095;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_responder #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .LIMIT(LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tid    = 0;
    int exp_conflicts  = 0;
    int seen_conflicts = 0;
    logic [31:0] last_rd = 32'h0;

    int          exp_lat_q [$];
    int          acc_q     [$];
    int          tid_q     [$];
    logic [31:0] exp_rd_q  [$];
    bit          exp_flt_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per ack.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.req_conflict === 1'b1) seen_conflicts++;
        if (rst === 1'b0 && bus.ack === 1'b1) begin
            if (exp_lat_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                int lat, acc, t;
                logic [31:0] erd;
                bit ef;
                lat = exp_lat_q.pop_front();
                acc = acc_q.pop_front();
                t   = tid_q.pop_front();
                erd = exp_rd_q.pop_front();
                ef  = exp_flt_q.pop_front();
                check($sformatf("latency_t%0d", t), 32'(cyc - acc), 32'(lat));
                check($sformatf("fault_t%0d", t), {31'd0, bus.fault}, {31'd0, ef});
                check($sformatf("rdata_t%0d", t), bus.rdata, erd);
            end
        end
    end

    // Issue one transfer from IDLE (called at a negedge) and wait for its ack.
    task automatic xfer(input bit rd, input bit wr, input bit wide,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input int lat, input bit flt);
        int n;
        bus.req_rd    = rd;
        bus.req_wr    = wr;
        bus.req_wide  = wide;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        if (rd && !wr && !flt) last_rd = exp_rd;
        if (rd && wr) exp_conflicts++;
        exp_lat_q.push_back(lat);
        acc_q.push_back(cyc);
        tid_q.push_back(tid);
        exp_rd_q.push_back(last_rd);
        exp_flt_q.push_back(flt);
        tid++;
        @(posedge clk);
        @(negedge clk);
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
        if (!flt) check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (bus.ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.req_rd    = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_wide  = 1'b0;
        bus.req_addr  = 12'h000;
        bus.req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy",     {31'd0, bus.busy},         32'd0);
        check("reset_ack",      {31'd0, bus.ack},          32'd0);
        check("reset_rdata",    bus.rdata,                 32'd0);
        check("reset_fault",    {31'd0, bus.fault},        32'd0);
        check("reset_conflict", {31'd0, bus.req_conflict}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Narrow write then read back.
        xfer(1'b0, 1'b1, 1'b0, 12'h010, 32'h0000_1234, 32'h0, 3, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 32'h0000_1234, 3, 1'b0);
        // Wide push / pop, then each half narrow.
        xfer(1'b0, 1'b1, 1'b1, 12'h7FE, 32'hDEAD_BEEF, 32'h0, 4, 1'b0);
        xfer(1'b1, 1'b0, 1'b1, 12'h7FE, 32'h0, 32'hDEAD_BEEF, 4, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 12'h7FF, 32'h0, 32'h0000_DEAD, 3, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 12'h7FE, 32'h0, 32'h0000_BEEF, 3, 1'b0);
        // Read and write together: write wins.
        xfer(1'b1, 1'b1, 1'b0, 12'h020, 32'h0000_BEEF, 32'h0, 3, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 12'h020, 32'h0, 32'h0000_BEEF, 3, 1'b0);
`ifdef DMEM_BOUNDS_EN
        // Out-of-range narrow read and wide write at the limit.
        xfer(1'b1, 1'b0, 1'b0, 12'h800, 32'h0, 32'h0, 1, 1'b1);
        xfer(1'b0, 1'b1, 1'b1, 12'h7FF, 32'h1234_5678, 32'h0, 1, 1'b1);
        xfer(1'b1, 1'b0, 1'b0, 12'h7FF, 32'h0, 32'h0000_DEAD, 3, 1'b0);
`else
        // Wide write at the top word wraps to word 0.
        xfer(1'b0, 1'b1, 1'b1, 12'hFFF, 32'hAAAA_5555, 32'h0, 4, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 12'hFFF, 32'h0, 32'h0000_5555, 3, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_AAAA, 3, 1'b0);
`endif

        // Reset during beat 1 of a wide write.
        xfer(1'b0, 1'b1, 1'b0, 12'h101, 32'h0000_3333, 32'h0, 3, 1'b0);
        bus.req_rd    = 1'b0;
        bus.req_wr    = 1'b1;
        bus.req_wide  = 1'b1;
        bus.req_addr  = 12'h100;
        bus.req_wdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        bus.req_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_ack",  {31'd0, bus.ack},  32'd0);
        rst = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        xfer(1'b1, 1'b0, 1'b0, 12'h100, 32'h0, 32'h0000_2222, 3, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 12'h101, 32'h0, 32'h0000_3333, 3, 1'b0);

        repeat (5) @(negedge clk);
        check("conflict_pulses", 32'(seen_conflicts), 32'(exp_conflicts));
        check("pending_acks", 32'(exp_lat_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
